// File: rtl/qr_r_stream_out.sv
// Captures an 8-row QR result frame, keeps the top D_WIDTH rows as R, and
// streams R back out element by element, forcing the lower triangle to zero.
module qr_r_stream_out #(
  parameter int D_WIDTH    = 4,
  parameter int DATA_WIDTH = 20,
  parameter int ROW_NUM    = 8,
  parameter int IDX_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [DATA_WIDTH*D_WIDTH-1:0] row_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic [IDX_W-1:0]              m_row_o,
  output logic [IDX_W-1:0]              m_col_o,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic                          overflow_o
);

  localparam int CNT_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int K_W   = (D_WIDTH > 1) ? $clog2(D_WIDTH * D_WIDTH) : 1;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(D_WIDTH * D_WIDTH - 1);
  localparam logic [K_W-1:0]   K_DW     = K_W'(D_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_KEEP = CNT_W'(D_WIDTH);

  typedef enum logic {S_COLLECT, S_DRAIN} state_t;

  state_t                       r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic [K_W-1:0]               r_k;
  logic                         r_overflow;
  logic signed [DATA_WIDTH-1:0] r_mem [D_WIDTH][D_WIDTH];

  logic                         w_drain;
  logic                         w_store;
  logic [IDX_W-1:0]             w_r;
  logic [IDX_W-1:0]             w_c;
  logic signed [DATA_WIDTH-1:0] w_elem;

  assign w_drain = (r_state == S_DRAIN);
  assign w_store = (r_state == S_COLLECT) && valid_i && (r_cnt < CNT_KEEP);
  assign w_r     = IDX_W'(r_k / K_DW);
  assign w_c     = IDX_W'(r_k % K_DW);
  assign w_elem  = r_mem[w_r][w_c];

  // R storage is not reset; the read side gates it with the drain state.
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int j = 0; j < D_WIDTH; j++) begin
        r_mem[IDX_W'(r_cnt)][j] <= row_i[DATA_WIDTH*(D_WIDTH-j)-1 -: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_COLLECT;
      r_cnt      <= '0;
      r_k        <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == S_COLLECT) begin
      if (valid_i) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_k     <= '0;
          r_state <= S_DRAIN;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end else begin
      // No upstream backpressure: rows arriving now are lost and flagged.
      if (valid_i) r_overflow <= 1'b1;
      if (m_ready_i) begin
        if (r_k == K_LAST) begin
          r_k     <= '0;
          r_state <= S_COLLECT;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  assign m_valid_o  = w_drain;
  assign busy_o     = w_drain;
  assign overflow_o = r_overflow;
  assign m_row_o    = w_r;
  assign m_col_o    = w_c;
  assign m_last_o   = w_drain && (r_k == K_LAST);
  assign m_data_o   = (w_drain && (w_c >= w_r)) ? w_elem : '0;

endmodule

// File: tb/tb_qr_r_stream_out.sv
// Self-checking bench for qr_r_stream_out: random and directed frames checked
// against a frame-level model of the expected upper-triangular stream.
module tb_qr_r_stream_out;

  localparam int D  = 4;
  localparam int DW = 20;
  localparam int RN = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic [DW*D-1:0] row_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic [IW-1:0] m_row_o;
  logic [IW-1:0] m_col_o;
  logic          m_last_o;
  logic          busy_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  qr_r_stream_out #(.D_WIDTH(D), .DATA_WIDTH(DW), .ROW_NUM(RN), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .row_i(row_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_row_o(m_row_o), .m_col_o(m_col_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  typedef struct packed {
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic [DW-1:0] d;
    logic          last;
  } elem_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] frame [RN][D];
  elem_t         exp_q [$];
  logic          ovf_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*D-1:0] pack_row(input int r);
    logic [DW*D-1:0] v;
    v = '0;
    for (int j = 0; j < D; j++) v[DW*(D-j)-1 -: DW] = frame[r][j];
    return v;
  endfunction

  task automatic fill_plan();
    for (int r = 0; r < RN; r++)
      for (int c = 0; c < D; c++) frame[r][c] = DW'(16 * r + c + 1);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < RN; r++)
      for (int c = 0; c < D; c++) frame[r][c] = DW'($urandom);
  endtask

  // Expected R stream: row-major over the top D rows, zero below the diagonal.
  task automatic build_expect();
    elem_t e;
    exp_q.delete();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        e.r    = IW'(r);
        e.c    = IW'(c);
        e.d    = (c >= r) ? frame[r][c] : '0;
        e.last = (r == D - 1) && (c == D - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic chk_reset();
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_ovf",   32'(overflow_o), 0);
    chk("rst_data",  32'(m_data_o), 0);
    chk("rst_row",   32'(m_row_o), 0);
    chk("rst_col",   32'(m_col_o), 0);
    chk("rst_last",  32'(m_last_o), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; valid_i = 1'b0; m_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ovf_exp = 1'b0;
    exp_q.delete();
    chk_reset();
  endtask

  // Called at a negedge; drives nrows rows on consecutive cycles.
  task automatic send_frame(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      chk("idle_valid", 32'(m_valid_o), 0);
      chk("idle_ovf", 32'(overflow_o), 32'(ovf_exp));
      valid_i   = 1'b1;
      row_i     = pack_row(r);
      m_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    valid_i   = 1'b0;
    m_ready_i = 1'b0;
    if (nrows == RN) build_expect();
  endtask

  // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic drain(input int mode, input int extra_rows, input bit row_on_last, input int max_pops);
    int  pops = 0;
    int  cyc  = 0;
    bit  rdy;
    bit  drop;
    while (exp_q.size() != 0 && pops < max_pops) begin
      if (cyc > 400) begin
        chk("drain_timeout", 1, 0);
        break;
      end
      chk("valid", 32'(m_valid_o), 1);
      chk("busy",  32'(busy_o), 1);
      chk("data",  32'(m_data_o), 32'(exp_q[0].d));
      chk("row",   32'(m_row_o), 32'(exp_q[0].r));
      chk("col",   32'(m_col_o), 32'(exp_q[0].c));
      chk("last",  32'(m_last_o), 32'(exp_q[0].last));
      chk("ovf",   32'(overflow_o), 32'(ovf_exp));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      drop = (cyc < extra_rows) || (row_on_last && rdy && exp_q.size() == 1);
      m_ready_i = rdy;
      valid_i   = drop;
      row_i     = (DW*D)'({$urandom, $urandom, $urandom});
      if (rdy) begin
        void'(exp_q.pop_front());
        pops++;
      end
      cyc++;
      @(negedge clk);
      if (drop) ovf_exp = 1'b1;
    end
    m_ready_i = 1'b0;
    valid_i   = 1'b0;
    if (exp_q.size() == 0) begin
      chk("valid_after", 32'(m_valid_o), 0);
      chk("busy_after",  32'(busy_o), 0);
      chk("ovf_after",   32'(overflow_o), 32'(ovf_exp));
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; m_ready_i = 1'b0; row_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset();
    rst = 1'b0;

    // Test-plan frame, full throughput
    fill_plan();
    send_frame(RN);
    chk("plan_00", 32'(exp_q[0].d), 1);
    drain(0, 0, 1'b0, 1000);

    // Same frame under a 1,0,0 ready pattern
    send_frame(RN);
    drain(1, 0, 1'b0, 1000);

    // Negative data in row 0
    fill_rand();
    for (int c = 0; c < D; c++) frame[0][c] = DW'(-5);
    send_frame(RN);
    drain(2, 0, 1'b0, 1000);

    // Rows during drain, plus one on the final handshake edge
    fill_rand();
    send_frame(RN);
    drain(0, 3, 1'b1, 1000);
    fill_rand();
    send_frame(RN);
    drain(2, 0, 1'b0, 1000);

    // Reset at drain element 5, then a fresh frame
    fill_plan();
    send_frame(RN);
    drain(0, 0, 1'b0, 5);
    pulse_reset();
    fill_rand();
    send_frame(RN);
    drain(0, 0, 1'b0, 1000);

    // Reset mid-frame abandons the partial frame
    fill_rand();
    send_frame(3);
    pulse_reset();
    fill_rand();
    send_frame(RN);
    drain(1, 0, 1'b0, 1000);

    // Back-to-back frames, next frame starts in the first COLLECT cycle
    fill_rand();
    send_frame(RN);
    drain(0, 0, 1'b0, 1000);
    fill_rand();
    send_frame(RN);
    drain(2, 0, 1'b0, 1000);
    chk("b2b_ovf", 32'(overflow_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
